// File: rtl/coms_pkg.sv
// Shared constants, state types and helpers for the coms_rx command receiver.
package coms_pkg;

  localparam logic [7:0]  SYNC_BYTE     = 8'hAA;
  localparam logic [7:0]  BROADCAST_ID  = 8'hFF;
  localparam int unsigned PAYLOAD_BYTES = 4;

  typedef enum logic [2:0] {
    P_WAIT_SYNC,
    P_ADDR,
    P_CMD,
    P_PAYLOAD,
    P_CHECK
  } parse_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, registered valid/error strobes.
module uart_rx_byte
  import coms_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s1;
  logic          rx_s2;
  byte_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= B_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        B_IDLE: begin
          cnt <= '0;
          if (!rx_s2) state <= B_START;
        end
        B_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_DATA: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            data <= {rx_s2, data[7:1]};
            if (bit_idx == 3'd7) state <= B_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_STOP: begin
          if (cnt == LAST) begin
            byte_valid <= rx_s2;
            byte_err   <= !rx_s2;
            state      <= B_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/coms_rx.sv
// Command frame receiver: parses SYNC/ADDR/CMD/D0..D3/CHK frames from the UART byte stream.
module coms_rx
  import coms_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  NODE_ID      = 8'h01,
  parameter int unsigned TIMEOUT_CLKS = 160
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rx_i,
  output logic        cmd_valid,
  output logic [7:0]  cmd_id,
  output logic [31:0] cmd_data,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int unsigned   GW       = $clog2(TIMEOUT_CLKS);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CLKS - 1);
  localparam int unsigned   PW       = $clog2(PAYLOAD_BYTES);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_BYTES - 1);
  localparam int unsigned   PLW      = 8 * PAYLOAD_BYTES;

  logic [7:0]     data;
  logic           byte_valid;
  logic           byte_err;
  parse_state_t   state;
  logic [7:0]     sum;
  logic [7:0]     sum_next;
  logic           match;
  logic [7:0]     cmd_byte;
  logic [PW-1:0]  idx;
  logic [PLW-1:0] payload;
  logic [GW-1:0]  gap;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .CLK        (CLK),
    .reset      (reset),
    .rx_i       (rx_i),
    .data       (data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  assign sum_next = sum + data;

  // A byte landing on the last gap cycle wins over the timeout, so back-to-back bytes never abort.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= P_WAIT_SYNC;
      sum       <= '0;
      match     <= 1'b0;
      cmd_byte  <= '0;
      idx       <= '0;
      payload   <= '0;
      gap       <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_id    <= '0;
      cmd_data  <= '0;
      err_count <= '0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == P_WAIT_SYNC) begin
        gap <= '0;
        if (byte_valid && data == SYNC_BYTE) state <= P_ADDR;
      end else if (byte_err || (!byte_valid && gap == GAP_LAST)) begin
        frame_err <= 1'b1;
        err_count <= sat_inc8(err_count);
        gap       <= '0;
        state     <= P_WAIT_SYNC;
      end else if (byte_valid) begin
        gap <= '0;
        sum <= sum_next;
        case (state)
          P_ADDR: begin
            sum   <= data;
            match <= (data == NODE_ID) || (data == BROADCAST_ID);
            state <= P_CMD;
          end
          P_CMD: begin
            cmd_byte <= data;
            idx      <= '0;
            state    <= P_PAYLOAD;
          end
          P_PAYLOAD: begin
            payload <= {data, payload[PLW-1:8]};
            if (idx == PAY_LAST) state <= P_CHECK;
            else                 idx   <= idx + PW'(1);
          end
          P_CHECK: begin
            state <= P_WAIT_SYNC;
            if (sum_next != 8'h00) begin
              frame_err <= 1'b1;
              err_count <= sat_inc8(err_count);
            end else if (match) begin
              cmd_valid <= 1'b1;
              cmd_id    <= cmd_byte;
              cmd_data  <= payload;
            end
          end
          default: state <= P_WAIT_SYNC;
        endcase
      end else begin
        gap <= gap + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_coms_rx.sv
// Scoreboard bench for coms_rx: a frame-level model queues expected pulses, a monitor pops and compares.
module tb_coms_rx;
  import coms_pkg::*;

  localparam int unsigned CPB  = 8;
  localparam logic [7:0]  NODE = 8'h01;
  localparam int unsigned TMO  = 10 * CPB;

  logic        CLK = 1'b0;
  logic        reset;
  logic        rx_i;
  logic        cmd_valid;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_data;
  logic        frame_err;
  logic [7:0]  err_count;

  always #5 CLK = ~CLK;

  coms_rx #(.CLKS_PER_BIT(CPB), .NODE_ID(NODE), .TIMEOUT_CLKS(TMO)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .rx_i      (rx_i),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .cmd_data  (cmd_data),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  id;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         model_cnt = 0;
  logic [7:0] frame[8];
  logic       prev_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_err();
    model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
    exp_q.push_back('{1'b1, 8'h00, 32'h0, 8'(model_cnt)});
  endfunction

  // Frame-level reference: aborted or bad-sum frames error, good sums addressed to us produce a command.
  function automatic void model_frame(input int bad_idx);
    logic [7:0] s;
    s = 8'h00;
    if (bad_idx > 0) begin
      push_err();
      return;
    end
    for (int i = 1; i < 8; i++) s = s + frame[i];
    if (s != 8'h00) push_err();
    else if (frame[1] == NODE || frame[1] == 8'hFF)
      exp_q.push_back('{1'b0, frame[2], {frame[6], frame[5], frame[4], frame[3]}, 8'(model_cnt)});
  endfunction

  function automatic void set_frame(input logic [7:0] addr, input logic [7:0] cmd,
                                    input logic [31:0] d, input bit auto_chk, input logic [7:0] chk);
    logic [7:0] s;
    frame[0] = 8'hAA;
    frame[1] = addr;
    frame[2] = cmd;
    frame[3] = d[7:0];
    frame[4] = d[15:8];
    frame[5] = d[23:16];
    frame[6] = d[31:24];
    s = 8'h00;
    for (int i = 1; i < 7; i++) s = s + frame[i];
    frame[7] = auto_chk ? 8'(8'h00 - s) : chk;
  endfunction

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx_i = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx_i = stop_ok;
    repeat (CPB) @(negedge CLK);
    rx_i = 1'b1;
  endtask

  // A bad stop bit abandons the rest of the frame and leaves the line idle long enough to resettle.
  task automatic send_frame(input int bad_idx);
    model_frame(bad_idx);
    for (int i = 0; i < 8; i++) begin
      send_byte(frame[i], i != bad_idx);
      if (i == bad_idx) begin
        idle(12 * CPB);
        return;
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      check("pulse_width", 64'(prev_pulse & (cmd_valid | frame_err)), 64'd0);
      if (cmd_valid || frame_err) begin
        check("pulse_exclusive", 64'(cmd_valid & frame_err), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'({cmd_valid, frame_err}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 64'(frame_err), 64'(e.is_err));
          if (!e.is_err) begin
            check("cmd_id", 64'(cmd_id), 64'(e.id));
            check("cmd_data", 64'(cmd_data), 64'(e.data));
          end
          check("err_count", 64'(err_count), 64'(e.cnt));
        end
      end
    end
    prev_pulse <= (cmd_valid | frame_err) & !reset;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] addr;
    int         r;
    int         bad;

    reset = 1'b1;
    rx_i  = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_cmd_id", 64'(cmd_id), 64'd0);
    check("rst_cmd_data", 64'(cmd_data), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    reset = 1'b0;
    idle(4 * CPB);

    // Directed frames, sent back to back with no idle between them.
    set_frame(8'h01, 8'h10, 32'h12345678, 1'b0, 8'hDB);
    send_frame(-1);
    set_frame(8'h01, 8'h10, 32'h12345678, 1'b0, 8'hDC);
    send_frame(-1);
    set_frame(8'h02, 8'h10, 32'h12345678, 1'b0, 8'hDA);
    send_frame(-1);
    set_frame(8'hFF, 8'h10, 32'h12345678, 1'b1, 8'h00);
    send_frame(-1);
    idle(2 * CPB);

    // Line noise before a good frame.
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(3 * CPB);
    rx_i = 1'b0;
    repeat (3) @(negedge CLK);
    idle(3 * CPB);
    set_frame(8'h01, 8'h22, 32'hCAFEF00D, 1'b1, 8'h00);
    send_frame(-1);

    // Stop bit low on D2, then a good frame.
    set_frame(8'h01, 8'h10, 32'h12345678, 1'b0, 8'hDB);
    send_frame(5);
    set_frame(8'h01, 8'h33, 32'h0BADBEEF, 1'b1, 8'h00);
    send_frame(-1);

    // 200-cycle gap after CMD: timeout, and the tail bytes are discarded.
    set_frame(8'h01, 8'h10, 32'h12345678, 1'b0, 8'hDB);
    push_err();
    for (int i = 0; i < 3; i++) send_byte(frame[i], 1'b1);
    idle(200);
    for (int i = 3; i < 8; i++) send_byte(frame[i], 1'b1);
    idle(2 * CPB);

    // Randomized frames.
    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 3));
      addr = (r == 0) ? NODE : (r == 1) ? 8'hFF : (r == 2) ? 8'($urandom_range(2, 254)) : 8'h00;
      set_frame(addr, 8'($urandom), 32'($urandom), $urandom_range(0, 3) != 0, 8'($urandom));
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : -1;
      send_frame(bad);
      idle(($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 30)));
    end

    // Drive the error counter to saturation with quick timeout aborts, then bad-sum frames.
    idle(2 * CPB);
    while (model_cnt < 255) begin
      push_err();
      send_byte(8'hAA, 1'b1);
      idle(TMO + 10);
    end
    for (int n = 0; n < 4; n++) begin
      set_frame(NODE, 8'($urandom), 32'($urandom), 1'b1, 8'h00);
      frame[7] = frame[7] + 8'h01;
      send_frame(-1);
    end
    idle(4 * CPB);
    check("err_count_saturated", 64'(err_count), 64'd255);

    // Reset in the middle of a byte inside a frame.
    check("queue_before_reset", 64'(exp_q.size()), 64'd0);
    send_byte(8'hAA, 1'b1);
    send_byte(NODE, 1'b1);
    rx_i = 1'b0;
    repeat (3 * CPB) @(negedge CLK);
    reset = 1'b1;
    rx_i  = 1'b1;
    @(negedge CLK);
    check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("mid_rst_frame_err", 64'(frame_err), 64'd0);
    check("mid_rst_cmd_id", 64'(cmd_id), 64'd0);
    check("mid_rst_cmd_data", 64'(cmd_data), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    @(negedge CLK);
    reset = 1'b0;
    model_cnt = 0;
    idle(4 * CPB);
    set_frame(8'h01, 8'h10, 32'h12345678, 1'b0, 8'hDB);
    send_frame(-1);

    idle(20 * CPB);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
